// File: rtl/mult_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_sched_pkg
// Description : Shared types and constants for the multiplier scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_sched_pkg;

    localparam int c_op_w            = 4;
    localparam int c_res_w           = 8;
    localparam int c_n_req_default   = 4;
    localparam int c_timeout_default = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Counter/index width for n values, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_sched_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin select, first set req at/after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import mult_sched_pkg::*;
#(
    parameter int N_REQ = c_n_req_default,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] index_o,
    output logic             valid_o
);

    int w_j;

    // Scan offsets from the far end so the nearest hit to the pointer wins.
    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        w_j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_j = int'(rr_ptr_i) + k;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            if (req_i[w_j]) begin
                valid_o = 1'b1;
                index_o = IDX_W'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : mult_sched
// Description : Round-robin scheduler sharing one signed 4x4 multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int N_REQ   = c_n_req_default,
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [c_op_w*N_REQ-1:0]   a_in,
    input  logic [c_op_w*N_REQ-1:0]   b_in,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          ack,
    output logic [c_res_w-1:0]        result,
    output logic                      err,
    output logic                      busy,
    output logic                      mul_start,
    output logic [c_op_w-1:0]         mul_a,
    output logic [c_op_w-1:0]         mul_b,
    input  logic                      mul_done,
    input  logic [c_res_w-1:0]        mul_result
);

    localparam int               IDX_W      = idx_w(N_REQ);
    localparam int               TMR_W      = idx_w(TIMEOUT);
    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N_REQ - 1);

    state_t               state_q,  state_d;
    logic [IDX_W-1:0]     owner_q,  owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]     timer_q,  timer_d;
    logic [c_op_w-1:0]    opa_q,    opa_d;
    logic [c_op_w-1:0]    opb_q,    opb_d;
    logic [c_res_w-1:0]   result_q, result_d;
    logic                 err_q,    err_d;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [c_op_w-1:0]    sel_a;
    logic [c_op_w-1:0]    sel_b;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .index_o  (pick_idx),
        .valid_o  (pick_valid)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_a = a_in[i*c_op_w +: c_op_w];
                sel_b = b_in[i*c_op_w +: c_op_w];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            timer_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            timer_q  <= timer_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // mul_done only matters in WAIT; every other state drops it.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        timer_d  = timer_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    opa_d   = sel_a;
                    opb_d   = sel_b;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    result_d = mul_result;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (timer_q == c_tmr_last) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (owner_q == c_idx_last) ? '0 : owner_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign mul_start = (state_q == ST_ISSUE);
    assign mul_a     = opa_q;
    assign mul_b     = opb_q;
    assign result    = result_q;
    assign err       = err_q;

    always_comb begin
        grant = '0;
        ack   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = busy && (owner_q == IDX_W'(i));
            ack[i]   = (state_q == ST_RESP) && (owner_q == IDX_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_sched
// Description : Directed self-checking bench for mult_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = 4'b0;
    logic [15:0] a_in  = 16'h0;
    logic [15:0] b_in  = 16'h0;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  result;
    logic        err;
    logic        busy;
    logic        mul_start;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic        mul_done   = 1'b0;
    logic [7:0]  mul_result = 8'h0;

    int tests_run    = 0;
    int tests_failed = 0;
    int start_cnt    = 0;
    logic resp_en    = 1'b0;
    int resp_lat     = 1;
    logic signed [7:0] pa, pb;

    mult_sched #(.N_REQ(4), .TIMEOUT(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .grant      (grant),
        .ack        (ack),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    always #5 clock = ~clock;

    // Multiplier stand-in: answers resp_lat cycles after the start pulse.
    always begin
        @(negedge clock);
        if (resp_en && mul_start) begin
            pa = {{4{mul_a[3]}}, mul_a};
            pb = {{4{mul_b[3]}}, mul_b};
            repeat (resp_lat) @(negedge clock);
            mul_done   = 1'b1;
            mul_result = pa * pb;
            @(negedge clock);
            mul_done   = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (mul_start) start_cnt++;
    end

    task automatic wait_ack(input int max_cyc, input bit drop, output logic [3:0] ack_seen,
                            output int ncyc, output logic [7:0] res, output logic e,
                            output bit onehot_ok);
        ack_seen  = 4'b0;
        ncyc      = 0;
        res       = 8'h0;
        e         = 1'b0;
        onehot_ok = 1'b1;
        while (ncyc < max_cyc) begin
            @(negedge clock);
            ncyc++;
            if (busy ? !$onehot(grant) : (grant != 4'b0)) onehot_ok = 1'b0;
            if (ack != 4'b0) begin
                ack_seen = ack;
                res      = result;
                e        = err;
                if (drop) req = req & ~ack;
                break;
            end
        end
    endtask

    task automatic test_reset();
        req = 4'b1111;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({busy, grant, ack, mul_start} !== 10'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b, expected 0", {busy, grant, ack, mul_start});
        end
        tests_run++;
        if ({mul_a, mul_b, result, err} !== 17'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h, expected 0", {mul_a, mul_b, result, err});
        end
        req   = 4'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        logic [3:0] a_s; int n; logic [7:0] r; logic e; bit oh;
        a_in = 16'h0004; b_in = 16'h0003;
        start_cnt = 0; resp_en = 1'b1; resp_lat = 5;
        req = 4'b0001;
        wait_ack(40, 1'b1, a_s, n, r, e, oh);
        tests_run++;
        if (a_s !== 4'b0001) begin tests_failed++; $display("FAIL basic_ack: got %b, expected 0001", a_s); end
        tests_run++;
        if (r !== 8'd12 || e !== 1'b0) begin tests_failed++; $display("FAIL basic_result: got %h err %b, expected 0c err 0", r, e); end
        tests_run++;
        if (n !== 7) begin tests_failed++; $display("FAIL basic_latency: got %0d, expected 7", n); end
        tests_run++;
        if (start_cnt !== 1) begin tests_failed++; $display("FAIL basic_start_pulses: got %0d, expected 1", start_cnt); end
        @(negedge clock);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_idle: got busy %b, expected 0", busy); end
    endtask

    task automatic test_signed();
        logic [3:0] a_s; int n; logic [7:0] r; logic e; bit oh;
        a_in = 16'h00D0; b_in = 16'h0050;
        resp_en = 1'b1; resp_lat = 2;
        req = 4'b0010;
        wait_ack(40, 1'b1, a_s, n, r, e, oh);
        tests_run++;
        if (a_s !== 4'b0010 || r !== 8'hF1 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL signed_product: got ack %b res %h err %b, expected 0010 f1 0", a_s, r, e);
        end
        tests_run++;
        if (n !== 4) begin tests_failed++; $display("FAIL signed_latency: got %0d, expected 4", n); end
        @(negedge clock);
    endtask

    task automatic test_ignore_done();
        resp_en = 1'b0;
        a_in = 16'h0100; b_in = 16'h0100;
        req = 4'b0100; mul_done = 1'b1; mul_result = 8'h55;
        @(negedge clock);
        tests_run++;
        if (mul_start !== 1'b1 || grant !== 4'b0100) begin
            tests_failed++;
            $display("FAIL issue_start: got start %b grant %b, expected 1 0100", mul_start, grant);
        end
        @(negedge clock);
        mul_done = 1'b0;
        @(negedge clock);
        mul_done = 1'b1; mul_result = 8'h21;
        @(negedge clock);
        mul_done = 1'b0;
        tests_run++;
        if (ack !== 4'b0100 || result !== 8'h21 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_early_done: got ack %b res %h err %b, expected 0100 21 0", ack, result, err);
        end
        req = 4'b0;
        @(negedge clock);
    endtask

    task automatic test_all_four();
        logic [3:0] a_s; int n; logic [7:0] r; logic e; bit oh;
        logic [7:0] exp_r [4];
        exp_r[0] = 8'h07; exp_r[1] = 8'hFC; exp_r[2] = 8'h09; exp_r[3] = 8'h40;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        a_in = 16'h8321; b_in = 16'h83E7;
        resp_en = 1'b1; resp_lat = 1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(30, 1'b1, a_s, n, r, e, oh);
            tests_run++;
            if (a_s !== (4'b0001 << i) || r !== exp_r[i] || !oh) begin
                tests_failed++;
                $display("FAIL all_four_op%0d: got ack %b res %h onehot %b, expected %b %h 1",
                         i, a_s, r, oh, 4'b0001 << i, exp_r[i]);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [3:0] a_s; int n; logic [7:0] r; logic e; bit oh;
        a_in = 16'h0503; b_in = 16'h090F;
        resp_en = 1'b1; resp_lat = 1;
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wait_ack(30, 1'b0, a_s, n, r, e, oh);
            tests_run++;
            if (a_s !== ((i % 2 == 0) ? 4'b0001 : 4'b0100) || r !== ((i % 2 == 0) ? 8'hFD : 8'hDD) || !oh) begin
                tests_failed++;
                $display("FAIL alternate_op%0d: got ack %b res %h onehot %b", i, a_s, r, oh);
            end
        end
        req = 4'b0;
        @(negedge clock);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL alternate_idle: got busy %b, expected 0", busy); end
    endtask

    task automatic test_timeout();
        logic [3:0] a_s; int n; logic [7:0] r; logic e; bit oh;
        resp_en = 1'b0;
        a_in = 16'h0070; b_in = 16'h0070;
        req = 4'b0010;
        wait_ack(60, 1'b1, a_s, n, r, e, oh);
        tests_run++;
        if (a_s !== 4'b0010 || r !== 8'h00 || e !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_resp: got ack %b res %h err %b, expected 0010 00 1", a_s, r, e);
        end
        tests_run++;
        if (n !== 18) begin tests_failed++; $display("FAIL timeout_latency: got %0d, expected 18", n); end
        @(negedge clock);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_idle: got busy %b, expected 0", busy); end
    endtask

    task automatic test_reset_midop();
        logic [3:0] a_s; int n; logic [7:0] r; logic e; bit oh;
        resp_en = 1'b0;
        req = 4'b0100;
        repeat (2) @(negedge clock);
        reset = 1'b1; req = 4'b0;
        @(negedge clock);
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || ack !== 4'b0) begin
            tests_failed++;
            $display("FAIL midop_reset: got busy %b ack %b, expected 0 0000", busy, ack);
        end
        @(negedge clock);
        mul_done = 1'b1; mul_result = 8'h77;
        @(negedge clock);
        mul_done = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || ack !== 4'b0) begin
            tests_failed++;
            $display("FAIL midop_stale_done: got busy %b ack %b, expected 0 0000", busy, ack);
        end
        a_in = 16'h2001; b_in = 16'h2001;
        resp_en = 1'b1; resp_lat = 1;
        req = 4'b1000;
        wait_ack(30, 1'b1, a_s, n, r, e, oh);
        tests_run++;
        if (a_s !== 4'b1000 || r !== 8'h04) begin
            tests_failed++;
            $display("FAIL midop_req3: got ack %b res %h, expected 1000 04", a_s, r);
        end
        req = 4'b1001;
        wait_ack(30, 1'b1, a_s, n, r, e, oh);
        tests_run++;
        if (a_s !== 4'b0001 || r !== 8'h01) begin
            tests_failed++;
            $display("FAIL midop_ptr_wrap: got ack %b res %h, expected 0001 01", a_s, r);
        end
        req = 4'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_ignore_done();
        test_all_four();
        test_back_to_back();
        test_timeout();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
